control_loop_scheduler: RTL

- Fixed-rate sequencer for the flight control datapath; owns loop timing.
- Each loop period it fires the angle controller, then the body-rate controller, then the motor mixer, strictly in order, waiting for each stage's complete pulse before starting the next.
- Enforces a per-stage watchdog and counts overruns.
- Sits between the microsecond clock domain and the three compute blocks; those blocks no longer self-trigger.

---
 rtl/control_loop_scheduler.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/control_loop_scheduler.sv
// -----------------------------------------------------------------------------
// control_loop_scheduler
//
// Fixed-rate sequencer for the flight control datapath. A free-running period
// counter produces one tick every LOOP_PERIOD_US cycles while enabled. Each
// tick launches the angle controller, then the body-rate controller, then the
// motor mixer, strictly in order; each stage must return its complete pulse
// before the next stage is started. A per-stage watchdog traps a stage that
// never completes, and ticks that arrive while a sequence is still running are
// dropped and counted.
//
// Ports
//   us_clk          1 MHz system clock
//   reset           asynchronous, active-high reset
//   enable          level; 1 = generate loop ticks
//   clear_fault     one-cycle pulse; leaves the fault state
//   angle_complete  complete pulse from the angle controller
//   rate_complete   complete pulse from the body-rate controller
//   mixer_complete  complete pulse from the motor mixer
//   angle_start     one-cycle start pulse to the angle controller
//   rate_start      one-cycle start pulse to the body-rate controller
//   mixer_start     one-cycle start pulse to the motor mixer
//   loop_done       one-cycle pulse; all three stages finished this period
//   busy            high from the first start pulse until loop_done or fault
//   fault           sticky; a stage timed out
//   fault_stage     01 angle, 10 rate, 11 mixer, 00 none
//   overrun_count   saturating count of dropped ticks
// -----------------------------------------------------------------------------
module control_loop_scheduler #(
   parameter int unsigned LOOP_PERIOD_US   = 2500,
   parameter int unsigned STAGE_TIMEOUT_US = 200,
   parameter int unsigned CNT_WIDTH        = 16
) (
   input  logic       us_clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       clear_fault,
   input  logic       angle_complete,
   input  logic       rate_complete,
   input  logic       mixer_complete,
   output logic       angle_start,
   output logic       rate_start,
   output logic       mixer_start,
   output logic       loop_done,
   output logic       busy,
   output logic       fault,
   output logic [1:0] fault_stage,
   output logic [7:0] overrun_count
);

   localparam logic [3:0] ST_IDLE        = 4'd0;
   localparam logic [3:0] ST_START_ANGLE = 4'd1;
   localparam logic [3:0] ST_WAIT_ANGLE  = 4'd2;
   localparam logic [3:0] ST_START_RATE  = 4'd3;
   localparam logic [3:0] ST_WAIT_RATE   = 4'd4;
   localparam logic [3:0] ST_START_MIX   = 4'd5;
   localparam logic [3:0] ST_WAIT_MIX    = 4'd6;
   localparam logic [3:0] ST_DONE        = 4'd7;
   localparam logic [3:0] ST_FAULT       = 4'd8;

   localparam logic [CNT_WIDTH-1:0] PERIOD_LAST = CNT_WIDTH'(LOOP_PERIOD_US - 1);
   localparam logic [CNT_WIDTH-1:0] WD_LIMIT    = CNT_WIDTH'(STAGE_TIMEOUT_US - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

   logic [3:0]           state_q, state_d;
   logic [CNT_WIDTH-1:0] period_cnt_q, period_cnt_d;
   logic [CNT_WIDTH-1:0] wd_cnt_q, wd_cnt_d;
   logic                 angle_start_q, angle_start_d;
   logic                 rate_start_q, rate_start_d;
   logic                 mixer_start_q, mixer_start_d;
   logic                 loop_done_q, loop_done_d;
   logic                 busy_q, busy_d;
   logic                 fault_q, fault_d;
   logic [1:0]           fault_stage_q, fault_stage_d;
   logic [7:0]           overrun_count_q, overrun_count_d;

   logic                 tick;
   logic                 tick_dropped;
   logic [CNT_WIDTH-1:0] wd_next;
   logic                 wd_expired;

   // Period counter: held at 0 while disabled, so the first tick lands
   // exactly LOOP_PERIOD_US cycles after enable rises.
   always_comb begin
      tick         = enable && (period_cnt_q == PERIOD_LAST);
      period_cnt_d = '0;
      if (enable && !tick) begin
         period_cnt_d = period_cnt_q + CNT_ONE;
      end
   end

   // Sequencer. The watchdog is cleared in each START state, so in the k-th
   // WAIT cycle wd_next equals k; the stage faults when that count reaches
   // STAGE_TIMEOUT_US-1 unless its complete arrives on the same cycle.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // it unassigned; without this the tool would infer a latch.
      state_d         = state_q;
      wd_cnt_d        = wd_cnt_q;
      fault_d         = fault_q;
      fault_stage_d   = fault_stage_q;
      overrun_count_d = overrun_count_q;
      tick_dropped    = 1'b0;
      wd_next         = wd_cnt_q + CNT_ONE;
      wd_expired      = (wd_next == WD_LIMIT);

      case (state_q)
         ST_IDLE: begin
            if (tick) state_d = ST_START_ANGLE;
         end
         ST_START_ANGLE: begin
            tick_dropped = tick;
            wd_cnt_d     = '0;
            state_d      = ST_WAIT_ANGLE;
         end
         ST_WAIT_ANGLE: begin
            tick_dropped = tick;
            wd_cnt_d     = wd_next;
            if (angle_complete) begin
               state_d = ST_START_RATE;
            end else if (wd_expired) begin
               state_d       = ST_FAULT;
               fault_d       = 1'b1;
               fault_stage_d = 2'b01;
            end
         end
         ST_START_RATE: begin
            tick_dropped = tick;
            wd_cnt_d     = '0;
            state_d      = ST_WAIT_RATE;
         end
         ST_WAIT_RATE: begin
            tick_dropped = tick;
            wd_cnt_d     = wd_next;
            if (rate_complete) begin
               state_d = ST_START_MIX;
            end else if (wd_expired) begin
               state_d       = ST_FAULT;
               fault_d       = 1'b1;
               fault_stage_d = 2'b10;
            end
         end
         ST_START_MIX: begin
            tick_dropped = tick;
            wd_cnt_d     = '0;
            state_d      = ST_WAIT_MIX;
         end
         ST_WAIT_MIX: begin
            tick_dropped = tick;
            wd_cnt_d     = wd_next;
            if (mixer_complete) begin
               state_d = ST_DONE;
            end else if (wd_expired) begin
               state_d       = ST_FAULT;
               fault_d       = 1'b1;
               fault_stage_d = 2'b11;
            end
         end
         ST_DONE: begin
            // A tick landing on the DONE cycle starts the next loop directly.
            state_d = tick ? ST_START_ANGLE : ST_IDLE;
         end
         ST_FAULT: begin
            // Ticks are ignored here and are not counted as overruns.
            if (clear_fault) begin
               state_d       = ST_IDLE;
               fault_d       = 1'b0;
               fault_stage_d = 2'b00;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (tick_dropped && (overrun_count_q != 8'hFF)) begin
         overrun_count_d = overrun_count_q + 8'd1;
      end
   end

   // Outputs are decoded from the next state and registered, so each pulse
   // lines up with the cycle its state is occupied.
   always_comb begin
      angle_start_d = (state_d == ST_START_ANGLE);
      rate_start_d  = (state_d == ST_START_RATE);
      mixer_start_d = (state_d == ST_START_MIX);
      loop_done_d   = (state_d == ST_DONE);
      busy_d        = (state_d == ST_START_ANGLE) || (state_d == ST_WAIT_ANGLE) ||
                      (state_d == ST_START_RATE)  || (state_d == ST_WAIT_RATE)  ||
                      (state_d == ST_START_MIX)   || (state_d == ST_WAIT_MIX);
   end

   // NOTE: state updates use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge us_clk or posedge reset) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         period_cnt_q    <= '0;
         wd_cnt_q        <= '0;
         angle_start_q   <= 1'b0;
         rate_start_q    <= 1'b0;
         mixer_start_q   <= 1'b0;
         loop_done_q     <= 1'b0;
         busy_q          <= 1'b0;
         fault_q         <= 1'b0;
         fault_stage_q   <= 2'b00;
         overrun_count_q <= 8'd0;
      end else begin
         state_q         <= state_d;
         period_cnt_q    <= period_cnt_d;
         wd_cnt_q        <= wd_cnt_d;
         angle_start_q   <= angle_start_d;
         rate_start_q    <= rate_start_d;
         mixer_start_q   <= mixer_start_d;
         loop_done_q     <= loop_done_d;
         busy_q          <= busy_d;
         fault_q         <= fault_d;
         fault_stage_q   <= fault_stage_d;
         overrun_count_q <= overrun_count_d;
      end
   end

   assign angle_start   = angle_start_q;
   assign rate_start    = rate_start_q;
   assign mixer_start   = mixer_start_q;
   assign loop_done     = loop_done_q;
   assign busy          = busy_q;
   assign fault         = fault_q;
   assign fault_stage   = fault_stage_q;
   assign overrun_count = overrun_count_q;

endmodule
